// File: rtl/imm_gen_pipe_pkg.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_pkg : immediate-mode encodings shared by decode and execute
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imm_gen_pipe_pkg;

  localparam int IM_OP_W = 3;

  // Field codes are unchanged from the combinational mux; PREFIX takes a free code.
  typedef enum logic [IM_OP_W-1:0] {
    IM_OP_NOP      = 3'd0,
    IM_OP_S_E_3_0  = 3'd1,
    IM_OP_S_E_4_0  = 3'd2,
    IM_OP_S_E_7_0  = 3'd3,
    IM_OP_S_E_10_0 = 3'd4,
    IM_OP_Z_E_7_0  = 3'd5,
    IM_OP_PREFIX   = 3'd6
  } im_op_e;

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if : decode-side request and registered immediate result
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface imm_gen_pipe_if #(
  parameter int DATA_W = 16,
  parameter int INST_W = 16,
  parameter int OP_W   = 3
);
  logic [INST_W-1:0] inst;
  logic [OP_W-1:0]   im_op;
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] im_out;
  logic              im_valid;
  logic              pfx_busy;

  modport master (
    output inst, im_op, in_valid, stall, flush,
    input  im_out, im_valid, pfx_busy
  );

  modport slave (
    input  inst, im_op, in_valid, stall, flush,
    output im_out, im_valid, pfx_busy
  );
endinterface

`default_nettype wire

// File: rtl/imm_field_ext.sv
// ---------------------------------------------------------------------------
// imm_field_ext : combinational extract and sign/zero extend of the immediate field
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_field_ext
  import imm_gen_pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int INST_W = 16,
  parameter int OP_W   = 3
) (
  input  wire logic [INST_W-1:0] i_inst,
  input  wire logic [OP_W-1:0]   i_op,
  output logic      [DATA_W-1:0] o_field
);

  // Fill with the sign (or zero) first, then overlay the extracted field.
  always_comb begin
    o_field = '0;
    case (i_op)
      OP_W'(IM_OP_S_E_3_0): begin
        o_field      = {DATA_W{i_inst[3]}};
        o_field[3:0] = i_inst[3:0];
      end
      OP_W'(IM_OP_S_E_4_0): begin
        o_field      = {DATA_W{i_inst[4]}};
        o_field[4:0] = i_inst[4:0];
      end
      OP_W'(IM_OP_S_E_7_0): begin
        o_field      = {DATA_W{i_inst[7]}};
        o_field[7:0] = i_inst[7:0];
      end
      OP_W'(IM_OP_S_E_10_0): begin
        o_field       = {DATA_W{i_inst[10]}};
        o_field[10:0] = i_inst[10:0];
      end
      OP_W'(IM_OP_Z_E_7_0): begin
        o_field[7:0] = i_inst[7:0];
      end
      default: o_field = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe : registered immediate generator with prefix merge, stall and flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int INST_W = 16,
  parameter int OP_W   = 3,
  parameter int PFX_W  = 11,
  parameter int LOW_W  = 5
) (
  input wire logic clk,
  input wire logic rst,
  imm_gen_pipe_if.slave bus
);

  localparam int        HI_W     = DATA_W - LOW_W;
  localparam logic [0:0] IMG_IDLE = 1'b0;
  localparam logic [0:0] IMG_PFX  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [PFX_W-1:0]  r_prefix;
  logic [PFX_W-1:0]  w_prefix_nxt;
  logic [DATA_W-1:0] r_im_out;
  logic [DATA_W-1:0] w_im_out_nxt;
  logic              r_im_valid;
  logic              w_im_valid_nxt;
  logic [DATA_W-1:0] w_field;
  logic [HI_W-1:0]   w_pfx_ext;
  logic              w_take;
  logic              w_is_pfx;
  logic              w_is_nop;

  imm_field_ext #(
    .DATA_W (DATA_W),
    .INST_W (INST_W),
    .OP_W   (OP_W)
  ) u_field (
    .i_inst  (bus.inst),
    .i_op    (bus.im_op),
    .o_field (w_field)
  );

  assign w_take   = bus.in_valid && !bus.stall && !bus.flush;
  assign w_is_pfx = (bus.im_op == OP_W'(IM_OP_PREFIX));
  assign w_is_nop = (bus.im_op == OP_W'(IM_OP_NOP));

  always_comb begin
    w_pfx_ext              = {HI_W{r_prefix[PFX_W-1]}};
    w_pfx_ext[PFX_W-1:0]   = r_prefix;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IMG_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IMG_IDLE;
    end else if (w_take) begin
      case (r_state)
        IMG_IDLE: if (w_is_pfx) w_state_nxt = IMG_PFX;
        IMG_PFX:  if (!w_is_pfx && !w_is_nop) w_state_nxt = IMG_IDLE;
        default:  w_state_nxt = IMG_IDLE;
      endcase
    end
  end

  // Stall holds everything; a flush or an idle cycle only drops the valid.
  always_comb begin
    w_im_out_nxt   = r_im_out;
    w_im_valid_nxt = r_im_valid;
    w_prefix_nxt   = r_prefix;
    if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      w_im_valid_nxt = 1'b0;
    end else if (w_take) begin
      if (w_is_pfx) begin
        w_prefix_nxt   = bus.inst[PFX_W-1:0];
        w_im_valid_nxt = 1'b0;
      end else if (w_is_nop) begin
        w_im_out_nxt   = '0;
        w_im_valid_nxt = 1'b1;
      end else begin
        w_im_out_nxt   = (r_state == IMG_PFX) ? {w_pfx_ext, w_field[LOW_W-1:0]} : w_field;
        w_im_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_im_out   <= '0;
      r_im_valid <= 1'b0;
      r_prefix   <= '0;
    end else begin
      r_im_out   <= w_im_out_nxt;
      r_im_valid <= w_im_valid_nxt;
      r_prefix   <= w_prefix_nxt;
    end
  end

  assign bus.im_out   = r_im_out;
  assign bus.im_valid = r_im_valid;
  assign bus.pfx_busy = (r_state == IMG_PFX);

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe : directed vectors with hand-computed immediates
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  imm_gen_pipe_if #(.DATA_W(16), .INST_W(16), .OP_W(3)) bus ();

  imm_gen_pipe #(
    .DATA_W (16),
    .INST_W (16),
    .OP_W   (3),
    .PFX_W  (11),
    .LOW_W  (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [15:0] ins,
                      input logic st, input logic fl);
    bus.in_valid = v;
    bus.im_op    = op;
    bus.inst     = ins;
    bus.stall    = st;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic [15:0] o, input logic v, input logic b);
    check({tag, ".out"},  32'(bus.im_out),   32'(o));
    check({tag, ".vld"},  32'(bus.im_valid), 32'(v));
    check({tag, ".busy"}, 32'(bus.pfx_busy), 32'(b));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.im_op = '0; bus.inst = '0; bus.stall = 1'b0; bus.flush = 1'b0;

    step(1'b1, IM_OP_S_E_7_0, 16'h00F8, 1'b0, 1'b0);
    step(1'b1, IM_OP_S_E_7_0, 16'h00F8, 1'b0, 1'b0);
    expect3("reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;

    step(1'b1, IM_OP_S_E_7_0, 16'h00F8, 1'b0, 1'b0);
    expect3("sext7", 16'hFFF8, 1'b1, 1'b0);
    step(1'b1, IM_OP_Z_E_7_0, 16'h00F8, 1'b0, 1'b0);
    expect3("zext7", 16'h00F8, 1'b1, 1'b0);
    step(1'b1, IM_OP_S_E_10_0, 16'h0408, 1'b0, 1'b0);
    expect3("sext10", 16'hFC08, 1'b1, 1'b0);
    step(1'b1, IM_OP_S_E_3_0, 16'h000F, 1'b0, 1'b0);
    expect3("sext3", 16'hFFFF, 1'b1, 1'b0);
    step(1'b0, IM_OP_S_E_3_0, 16'h0000, 1'b0, 1'b0);
    expect3("bubble", 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b0);
    expect3("undef", 16'h0000, 1'b1, 1'b0);

    step(1'b1, IM_OP_PREFIX, 16'h0123, 1'b0, 1'b0);
    expect3("pfx", 16'h0000, 1'b0, 1'b1);
    step(1'b1, IM_OP_S_E_4_0, 16'h0015, 1'b0, 1'b0);
    expect3("merge", 16'h2475, 1'b1, 1'b0);

    step(1'b1, IM_OP_PREFIX, 16'h07FF, 1'b0, 1'b0);
    expect3("pfx7ff", 16'h2475, 1'b0, 1'b1);
    step(1'b1, IM_OP_NOP, 16'h1234, 1'b0, 1'b0);
    expect3("pfxnop", 16'h0000, 1'b1, 1'b1);
    step(1'b1, IM_OP_PREFIX, 16'h0001, 1'b0, 1'b0);
    expect3("repfx", 16'h0000, 1'b0, 1'b1);
    step(1'b1, IM_OP_S_E_3_0, 16'h0003, 1'b0, 1'b0);
    expect3("merge2", 16'h0023, 1'b1, 1'b0);

    step(1'b1, IM_OP_S_E_7_0, 16'h00F8, 1'b0, 1'b0);
    expect3("prestall", 16'hFFF8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, IM_OP_PREFIX, 16'h0012, 1'b1, 1'b0);
      expect3($sformatf("stall%0d", i), 16'hFFF8, 1'b1, 1'b0);
    end
    step(1'b1, IM_OP_Z_E_7_0, 16'h0012, 1'b0, 1'b0);
    expect3("unstall", 16'h0012, 1'b1, 1'b0);

    step(1'b1, IM_OP_PREFIX, 16'h0123, 1'b0, 1'b0);
    expect3("pfx2", 16'h0012, 1'b0, 1'b1);
    step(1'b1, IM_OP_S_E_4_0, 16'h0015, 1'b1, 1'b0);
    expect3("pfxstall", 16'h0012, 1'b0, 1'b1);
    step(1'b1, IM_OP_S_E_4_0, 16'h0015, 1'b1, 1'b1);
    expect3("flush", 16'h0012, 1'b0, 1'b0);
    step(1'b1, IM_OP_S_E_4_0, 16'h0015, 1'b0, 1'b0);
    expect3("postflush", 16'hFFF5, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
